// File: rtl/fu_sequencer.sv
// Issue/capture stage around functional_unit: registers one op, waits its
// class latency, then holds the captured result until downstream takes it.
module fu_sequencer #(
  parameter int unsigned MADD_LATENCY = 2,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_A,
  input  logic [31:0] IN_B,
  input  logic [31:0] IN_C,
  input  logic [4:0]  IN_INST,
  input  logic        IN_CI,
  output logic [31:0] FU_A,
  output logic [31:0] FU_B,
  output logic [31:0] FU_C,
  output logic [4:0]  FU_INST,
  output logic        FU_CI,
  input  logic [31:0] FU_Z,
  input  logic [3:0]  FU_FLAGS,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_Z,
  output logic [3:0]  OUT_FLAGS,
  output logic        BUSY
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [CNT_W-1:0] MADD_CNT = CNT_W'(MADD_LATENCY - 1);

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [31:0]      fu_a_q,      fu_a_d;
  logic [31:0]      fu_b_q,      fu_b_d;
  logic [31:0]      fu_c_q,      fu_c_d;
  logic [4:0]       fu_inst_q,   fu_inst_d;
  logic             fu_ci_q,     fu_ci_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_z_q,     out_z_d;
  logic [3:0]       out_flags_q, out_flags_d;
  logic             in_ready;
  logic             accept;

  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & OUT_READY);
  assign accept   = IN_VALID & in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fu_a_d      = fu_a_q;
    fu_b_d      = fu_b_q;
    fu_c_d      = fu_c_q;
    fu_inst_d   = fu_inst_q;
    fu_ci_d     = fu_ci_q;
    out_valid_d = out_valid_q;
    out_z_d     = out_z_q;
    out_flags_d = out_flags_q;

    case (state_q)
      ST_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          out_z_d     = FU_Z;
          out_flags_d = FU_FLAGS;
          out_valid_d = 1'b1;
          // Zeroing the instruction gates every functional-unit clock enable.
          fu_inst_d   = '0;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: ;
    endcase

    // A drain-cycle accept overrides the HOLD->IDLE move above.
    if (accept) begin
      fu_a_d    = IN_A;
      fu_b_d    = IN_B;
      fu_c_d    = IN_C;
      fu_inst_d = IN_INST;
      fu_ci_d   = IN_CI;
      cnt_d     = (IN_INST[4:3] == 2'b11) ? MADD_CNT : '0;
      state_d   = ST_EXEC;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fu_a_q      <= '0;
      fu_b_q      <= '0;
      fu_c_q      <= '0;
      fu_inst_q   <= '0;
      fu_ci_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fu_a_q      <= fu_a_d;
      fu_b_q      <= fu_b_d;
      fu_c_q      <= fu_c_d;
      fu_inst_q   <= fu_inst_d;
      fu_ci_q     <= fu_ci_d;
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign IN_READY  = in_ready;
  assign FU_A      = fu_a_q;
  assign FU_B      = fu_b_q;
  assign FU_C      = fu_c_q;
  assign FU_INST   = fu_inst_q;
  assign FU_CI     = fu_ci_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_Z     = out_z_q;
  assign OUT_FLAGS = out_flags_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fu_sequencer.sv
// Bench for fu_sequencer: table of single ops, hand-written corner sequences,
// and a randomized stream checked against a cycle-time reference model.
module tb_fu_sequencer;

  localparam int unsigned ML = 2;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] IN_A = '0, IN_B = '0, IN_C = '0;
  logic [4:0]  IN_INST = '0;
  logic        IN_CI = 1'b0;
  logic [31:0] FU_A, FU_B, FU_C;
  logic [4:0]  FU_INST;
  logic        FU_CI;
  logic [31:0] FU_Z;
  logic [3:0]  FU_FLAGS;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUT_Z;
  logic [3:0]  OUT_FLAGS;
  logic        BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  fu_sequencer #(.MADD_LATENCY(ML), .CNT_W(4)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_A(IN_A), .IN_B(IN_B), .IN_C(IN_C), .IN_INST(IN_INST), .IN_CI(IN_CI),
    .FU_A(FU_A), .FU_B(FU_B), .FU_C(FU_C), .FU_INST(FU_INST), .FU_CI(FU_CI),
    .FU_Z(FU_Z), .FU_FLAGS(FU_FLAGS),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_Z(OUT_Z), .OUT_FLAGS(OUT_FLAGS), .BUSY(BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  // Functional-unit stand-in: ALU is combinational, MADD has one pipeline
  // register so its result is only valid ML=2 edges after operand launch.
  logic [31:0] madd_c, madd_q;
  logic        fu_madd;
  assign madd_c  = FU_A * FU_B + FU_C;
  assign fu_madd = (FU_INST[4:3] == 2'b11);
  always @(posedge CLOCK) madd_q <= madd_c;
  assign FU_Z     = fu_madd ? madd_q : (FU_A + FU_B + {31'b0, FU_CI});
  assign FU_FLAGS = fu_madd ? 4'hF : FU_INST[3:0];

  function automatic logic [35:0] ref_op(input logic [4:0] inst, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c,
                                         input logic ci);
    if (inst[4:3] == 2'b11) return {4'hF, a * b + c};
    return {inst[3:0], a + b + {31'b0, ci}};
  endfunction

  function automatic int ref_lat(input logic [4:0] inst);
    return (inst[4:3] == 2'b11) ? int'(ML) : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  inst;
    logic [31:0] a, b, c;
    logic        ci;
    logic [31:0] z;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  task automatic drive_op(input logic [4:0] inst, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic ci);
    IN_INST = inst; IN_A = a; IN_B = b; IN_C = c; IN_CI = ci;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge CLOCK);
    drive_op(v.inst, v.a, v.b, v.c, v.ci);
    IN_VALID = 1'b1; OUT_READY = 1'b1;
    #1;
    chk("vec_in_ready_idle", 32'(IN_READY), 32'd1);
    chk("vec_busy_idle", 32'(BUSY), 32'd0);
    @(posedge CLOCK); #1;
    IN_VALID = 1'b0;
    chk("vec_fu_a", FU_A, v.a);
    chk("vec_fu_b", FU_B, v.b);
    chk("vec_fu_c", FU_C, v.c);
    chk("vec_fu_inst", 32'(FU_INST), 32'(v.inst));
    chk("vec_fu_ci", 32'(FU_CI), 32'(v.ci));
    chk("vec_busy_exec", 32'(BUSY), 32'd1);
    chk("vec_in_ready_exec", 32'(IN_READY), 32'd0);
    lat = 0;
    do begin
      @(posedge CLOCK); #1; lat++;
    end while (!OUT_VALID && lat < 20);
    chk("vec_latency", 32'(lat), 32'(v.lat));
    chk("vec_out_z", OUT_Z, v.z);
    chk("vec_out_flags", 32'(OUT_FLAGS), 32'(v.fl));
    chk("vec_fu_inst_hold", 32'(FU_INST), 32'd0);
    chk("vec_fu_a_hold", FU_A, v.a);
    @(posedge CLOCK); #1;
    chk("vec_drain_valid", 32'(OUT_VALID), 32'd0);
    chk("vec_drain_busy", 32'(BUSY), 32'd0);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge CLOCK); #1; lat++;
    end while (!OUT_VALID && lat < 20);
  endtask

  initial begin
    logic [31:0] held_z;
    int          lat;

    vecs[0] = '{5'b10000, 32'd5,          32'd3,          32'd0, 1'b0, 32'd8,          4'h0, 1};
    vecs[1] = '{5'b11100, 32'd2,          32'd3,          32'd4, 1'b1, 32'd10,         4'hF, 2};
    vecs[2] = '{5'b00101, 32'hFFFF_FFFF,  32'd1,          32'd9, 1'b1, 32'd1,          4'h5, 1};
    vecs[3] = '{5'b10111, 32'd0,          32'd0,          32'd0, 1'b1, 32'd1,          4'h7, 1};
    vecs[4] = '{5'b11000, 32'h0001_0000,  32'h0001_0000,  32'd7, 1'b0, 32'd7,          4'hF, 2};
    vecs[5] = '{5'b01111, 32'h7FFF_FFFF,  32'd1,          32'd0, 1'b0, 32'h8000_0000,  4'hF, 1};

    #12;
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_out_z", OUT_Z, 32'd0);
    chk("rst_out_flags", 32'(OUT_FLAGS), 32'd0);
    chk("rst_fu_a", FU_A, 32'd0);
    chk("rst_fu_inst", 32'(FU_INST), 32'd0);
    chk("rst_fu_ci", 32'(FU_CI), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    @(negedge CLOCK); RESET_N = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure, then drain and issue a MADD on the same edge.
    @(negedge CLOCK);
    drive_op(5'b10001, 32'd100, 32'd23, 32'd0, 1'b0);
    IN_VALID = 1'b1; OUT_READY = 1'b0;
    @(posedge CLOCK); #1;
    drive_op(5'b11111, 32'd6, 32'd7, 32'd8, 1'b0);
    wait_result(lat);
    chk("bp_latency", 32'(lat), 32'd1);
    held_z = OUT_Z;
    chk("bp_z", held_z, 32'd123);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLOCK); #1;
      chk("bp_out_valid", 32'(OUT_VALID), 32'd1);
      chk("bp_out_z_stable", OUT_Z, held_z);
      chk("bp_in_ready", 32'(IN_READY), 32'd0);
      chk("bp_fu_a_old", FU_A, 32'd100);
    end
    @(negedge CLOCK); OUT_READY = 1'b1;
    #1 chk("bp_in_ready_drain", 32'(IN_READY), 32'd1);
    @(posedge CLOCK); #1;
    IN_VALID = 1'b0;
    chk("di_out_valid_drop", 32'(OUT_VALID), 32'd0);
    chk("di_fu_a_new", FU_A, 32'd6);
    chk("di_fu_inst_new", 32'(FU_INST), 32'b11111);
    chk("di_busy", 32'(BUSY), 32'd1);
    wait_result(lat);
    chk("di_latency", 32'(lat), 32'(ML));
    chk("di_z", OUT_Z, 32'd50);
    @(posedge CLOCK); #1;
    chk("di_final_drain", 32'(OUT_VALID), 32'd0);

    // Reset one cycle into a MADD EXEC.
    @(negedge CLOCK);
    drive_op(5'b11010, 32'd3, 32'd3, 32'd3, 1'b0);
    IN_VALID = 1'b1;
    @(posedge CLOCK); #1 IN_VALID = 1'b0;
    @(negedge CLOCK); #1 RESET_N = 1'b0;
    #1;
    chk("rx_busy", 32'(BUSY), 32'd0);
    chk("rx_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rx_fu_inst", 32'(FU_INST), 32'd0);
    @(negedge CLOCK); RESET_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLOCK); #1;
      chk("rx_no_result", 32'(OUT_VALID), 32'd0);
    end

    // Reset while a result is being held.
    @(negedge CLOCK);
    drive_op(5'b00011, 32'd1, 32'd2, 32'd0, 1'b0);
    IN_VALID = 1'b1; OUT_READY = 1'b0;
    @(posedge CLOCK); #1 IN_VALID = 1'b0;
    wait_result(lat);
    chk("rh_pre_valid", 32'(OUT_VALID), 32'd1);
    @(negedge CLOCK); #1 RESET_N = 1'b0;
    #1;
    chk("rh_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rh_out_z", OUT_Z, 32'd0);
    chk("rh_busy", 32'(BUSY), 32'd0);
    @(negedge CLOCK); RESET_N = 1'b1;

    // Randomized stream against a time-based model: an op accepted after edge
    // e becomes visible after edge e+L and stays until drained.
    begin
      int          cyc = 0, issued = 0, drained = 0, avail = 0;
      bit          have_op = 0, outst = 0, exp_vis, exp_rdy, fire_in, fire_out;
      logic [35:0] exp_res = '0;
      while (drained < 20 && cyc < 2000) begin
        @(negedge CLOCK);
        if (!have_op && issued < 20 && ($urandom % 3) != 0) begin
          logic [4:0] inst;
          inst = 5'($urandom);
          if ($urandom % 2) inst[4:3] = 2'b11;
          drive_op(inst, $urandom, $urandom, $urandom, 1'($urandom));
          have_op = 1;
        end
        IN_VALID  = have_op;
        OUT_READY = ($urandom % 5) < 3;
        #1;
        exp_vis = outst && (cyc >= avail);
        exp_rdy = !outst || (exp_vis && OUT_READY);
        chk("st_out_valid", 32'(OUT_VALID), 32'(exp_vis));
        chk("st_in_ready", 32'(IN_READY), 32'(exp_rdy));
        chk("st_busy", 32'(BUSY), 32'(outst));
        if (exp_vis) begin
          chk("st_out_z", OUT_Z, exp_res[31:0]);
          chk("st_out_flags", 32'(OUT_FLAGS), 32'(exp_res[35:32]));
        end
        fire_in  = IN_VALID && exp_rdy;
        fire_out = exp_vis && OUT_READY;
        @(posedge CLOCK);
        cyc++;
        if (fire_out) begin
          outst = 0;
          drained++;
        end
        if (fire_in) begin
          outst   = 1;
          avail   = cyc + ref_lat(IN_INST);
          exp_res = ref_op(IN_INST, IN_A, IN_B, IN_C, IN_CI);
          have_op = 0;
          issued++;
        end
      end
      chk("st_drained_all", 32'(drained), 32'd20);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
